// File: rtl/ppi_port_a_strobed.sv
// rtl/ppi_port_a_strobed.sv - PPI port A strobed I/O stage (mode 1 handshake)
// Holds the port A latch/output register and runs the STB/IBF and OBF/ACK handshakes.

module ppi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_fall,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_hist;

    // Preset high so the idle-high handshake lines never fake an edge out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_hist <= 1'b1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_hist <= r_sync[STAGES-1];
        end
    end

    assign o_fall = r_hist & ~r_sync[STAGES-1];
    assign o_rise = ~r_hist & r_sync[STAGES-1];

endmodule

module ppi_port_a_strobed #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_dir,
    input  logic             cfg_inte,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    input  logic [WIDTH-1:0] pa_in,
    output logic [WIDTH-1:0] pa_out,
    output logic             pa_oe,
    input  logic             stb_n,
    output logic             ibf,
    input  logic             ack_n,
    output logic             obf_n,
    output logic             intr,
    output logic             overrun
);

    logic [WIDTH-1:0] r_latch;
    logic [WIDTH-1:0] r_pa_out;
    logic             r_ibf;
    logic             r_obf_n;
    logic             r_intr_req;
    logic             r_overrun;
    logic             r_pa_oe;
    logic             r_dir_q;

    logic             w_stb_fall;
    logic             w_stb_rise;
    logic             w_ack_fall;
    logic             w_ack_rise;
    logic             w_dir_chg;

    ppi_sync_edge #(.STAGES(SYNC_STAGES)) u_stb_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (stb_n),
        .o_fall  (w_stb_fall),
        .o_rise  (w_stb_rise)
    );

    ppi_sync_edge #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (ack_n),
        .o_fall  (w_ack_fall),
        .o_rise  (w_ack_rise)
    );

    assign w_dir_chg = r_dir_q ^ cfg_dir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_latch    <= '0;
            r_pa_out   <= '0;
            r_ibf      <= 1'b0;
            r_obf_n    <= 1'b1;
            r_intr_req <= 1'b0;
            r_overrun  <= 1'b0;
            r_pa_oe    <= 1'b0;
            r_dir_q    <= 1'b1;
        end else begin
            r_dir_q <= cfg_dir;
            r_pa_oe <= ~cfg_dir;
            // A direction flip abandons any handshake in flight; the latch survives
            if (w_dir_chg) begin
                r_ibf      <= 1'b0;
                r_overrun  <= 1'b0;
                r_intr_req <= 1'b0;
                r_obf_n    <= 1'b1;
            end else if (cfg_dir) begin
                if (w_stb_fall) begin
                    // A read in the same cycle drains the old byte, so new data is not an overrun
                    if (!r_ibf || rd_en) begin
                        r_latch <= pa_in;
                        r_ibf   <= 1'b1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                end else if (rd_en) begin
                    r_ibf <= 1'b0;
                end
                if (rd_en) begin
                    r_intr_req <= 1'b0;
                end else if (w_stb_rise && r_ibf) begin
                    r_intr_req <= 1'b1;
                end
            end else begin
                if (wr_en) begin
                    r_pa_out   <= bus_in;
                    r_obf_n    <= 1'b0;
                    r_intr_req <= 1'b0;
                end else begin
                    if (w_ack_fall) begin
                        r_obf_n <= 1'b1;
                    end
                    if (w_ack_rise && r_obf_n) begin
                        r_intr_req <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus_oe  = rd_en;
    assign bus_out = rd_en ? (cfg_dir ? r_latch : r_pa_out) : '0;
    assign pa_out  = r_pa_out;
    assign pa_oe   = r_pa_oe;
    assign ibf     = r_ibf;
    assign obf_n   = r_obf_n;
    assign intr    = r_intr_req & cfg_inte;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_ppi_port_a_strobed.sv
// tb/tb_ppi_port_a_strobed.sv - table-driven bench for ppi_port_a_strobed
module tb_ppi_port_a_strobed;

    typedef struct {
        logic       dir, inte, wr, rd;
        logic [7:0] bin, pin;
        logic       stb, ack;
        logic [7:0] e_bo;
        logic       e_boe, e_ibf, e_obfn, e_intr, e_ovr, e_paoe;
        logic [7:0] e_pao;
    } vec_t;

    localparam int NV = 33;

    logic       clk = 1'b0;
    logic       rst_n, cfg_dir, cfg_inte, wr_en, rd_en, stb_n, ack_n;
    logic [7:0] bus_in, pa_in;
    logic [7:0] bus_out, pa_out;
    logic       bus_oe, pa_oe, ibf, obf_n, intr, overrun;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t tbl[NV];

    ppi_port_a_strobed #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_dir(cfg_dir), .cfg_inte(cfg_inte),
        .wr_en(wr_en), .rd_en(rd_en), .bus_in(bus_in), .bus_out(bus_out),
        .bus_oe(bus_oe), .pa_in(pa_in), .pa_out(pa_out), .pa_oe(pa_oe),
        .stb_n(stb_n), .ibf(ibf), .ack_n(ack_n), .obf_n(obf_n),
        .intr(intr), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] v);
        pa_in = v;
        stb_n = 1'b0;
        repeat (4) tick();
        stb_n = 1'b1;
        repeat (3) tick();
    endtask

    function automatic vec_t row(input logic d, input logic ie, input logic w, input logic r,
                                 input logic [7:0] bi, input logic [7:0] pi,
                                 input logic s, input logic a,
                                 input logic [7:0] bo, input logic boe, input logic ib,
                                 input logic ob, input logic it, input logic ov,
                                 input logic oe, input logic [7:0] po);
        vec_t v;
        v.dir = d; v.inte = ie; v.wr = w; v.rd = r; v.bin = bi; v.pin = pi;
        v.stb = s; v.ack = a; v.e_bo = bo; v.e_boe = boe; v.e_ibf = ib;
        v.e_obfn = ob; v.e_intr = it; v.e_ovr = ov; v.e_paoe = oe; v.e_pao = po;
        return v;
    endfunction

    initial begin
        // input capture of A5, interrupt on strobe rise, read
        tbl[0]  = row(1,1,0,0,8'h00,8'hA5,0,1, 8'h00,0,0,1,0,0,0,8'h00);
        tbl[1]  = row(1,1,0,0,8'h00,8'hA5,0,1, 8'h00,0,0,1,0,0,0,8'h00);
        tbl[2]  = row(1,1,0,0,8'h00,8'hA5,0,1, 8'h00,0,1,1,0,0,0,8'h00);
        tbl[3]  = row(1,1,0,0,8'h00,8'hA5,0,1, 8'h00,0,1,1,0,0,0,8'h00);
        tbl[4]  = row(1,1,0,0,8'h00,8'hA5,0,1, 8'h00,0,1,1,0,0,0,8'h00);
        tbl[5]  = row(1,1,0,0,8'h00,8'hA5,1,1, 8'h00,0,1,1,0,0,0,8'h00);
        tbl[6]  = row(1,1,0,0,8'h00,8'hA5,1,1, 8'h00,0,1,1,0,0,0,8'h00);
        tbl[7]  = row(1,1,0,0,8'h00,8'hA5,1,1, 8'h00,0,1,1,1,0,0,8'h00);
        tbl[8]  = row(1,1,0,1,8'h00,8'hA5,1,1, 8'hA5,1,0,1,0,0,0,8'h00);
        tbl[9]  = row(1,1,0,0,8'h00,8'hA5,1,1, 8'h00,0,0,1,0,0,0,8'h00);
        // overrun: 11 captured, 22 strobed before any read
        tbl[10] = row(1,1,0,0,8'h00,8'h11,0,1, 8'h00,0,0,1,0,0,0,8'h00);
        tbl[11] = row(1,1,0,0,8'h00,8'h11,0,1, 8'h00,0,0,1,0,0,0,8'h00);
        tbl[12] = row(1,1,0,0,8'h00,8'h11,0,1, 8'h00,0,1,1,0,0,0,8'h00);
        tbl[13] = row(1,1,0,0,8'h00,8'h11,1,1, 8'h00,0,1,1,0,0,0,8'h00);
        tbl[14] = row(1,1,0,0,8'h00,8'h11,1,1, 8'h00,0,1,1,0,0,0,8'h00);
        tbl[15] = row(1,1,0,0,8'h00,8'h11,1,1, 8'h00,0,1,1,1,0,0,8'h00);
        tbl[16] = row(1,1,0,0,8'h00,8'h22,0,1, 8'h00,0,1,1,1,0,0,8'h00);
        tbl[17] = row(1,1,0,0,8'h00,8'h22,0,1, 8'h00,0,1,1,1,0,0,8'h00);
        tbl[18] = row(1,1,0,0,8'h00,8'h22,0,1, 8'h00,0,1,1,1,1,0,8'h00);
        tbl[19] = row(1,1,0,0,8'h00,8'h22,1,1, 8'h00,0,1,1,1,1,0,8'h00);
        tbl[20] = row(1,1,0,0,8'h00,8'h22,1,1, 8'h00,0,1,1,1,1,0,8'h00);
        tbl[21] = row(1,1,0,0,8'h00,8'h22,1,1, 8'h00,0,1,1,1,1,0,8'h00);
        tbl[22] = row(1,1,0,1,8'h00,8'h22,1,1, 8'h11,1,0,1,0,1,0,8'h00);
        // output mode: write 3C, ack handshake, read-back, rewrite clears intr
        tbl[23] = row(0,1,0,0,8'h00,8'h00,1,1, 8'h00,0,0,1,0,0,1,8'h00);
        tbl[24] = row(0,1,1,0,8'h3C,8'h00,1,1, 8'h00,0,0,0,0,0,1,8'h3C);
        tbl[25] = row(0,1,0,0,8'h00,8'h00,1,0, 8'h00,0,0,0,0,0,1,8'h3C);
        tbl[26] = row(0,1,0,0,8'h00,8'h00,1,0, 8'h00,0,0,0,0,0,1,8'h3C);
        tbl[27] = row(0,1,0,0,8'h00,8'h00,1,0, 8'h00,0,0,1,0,0,1,8'h3C);
        tbl[28] = row(0,1,0,0,8'h00,8'h00,1,1, 8'h00,0,0,1,0,0,1,8'h3C);
        tbl[29] = row(0,1,0,0,8'h00,8'h00,1,1, 8'h00,0,0,1,0,0,1,8'h3C);
        tbl[30] = row(0,1,0,0,8'h00,8'h00,1,1, 8'h00,0,0,1,1,0,1,8'h3C);
        tbl[31] = row(0,1,0,1,8'h00,8'h00,1,1, 8'h3C,1,0,1,1,0,1,8'h3C);
        tbl[32] = row(0,1,1,0,8'h5A,8'h00,1,1, 8'h00,0,0,0,0,0,1,8'h5A);

        rst_n = 1'b0; cfg_dir = 1'b1; cfg_inte = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        bus_in = 8'h00; pa_in = 8'h00; stb_n = 1'b1; ack_n = 1'b1;
        tick(); tick();
        chk("reset ibf", {7'd0, ibf}, 8'd0);
        chk("reset obf_n", {7'd0, obf_n}, 8'd1);
        chk("reset intr", {7'd0, intr}, 8'd0);
        chk("reset overrun", {7'd0, overrun}, 8'd0);
        chk("reset pa_oe", {7'd0, pa_oe}, 8'd0);
        chk("reset pa_out", pa_out, 8'h00);
        chk("reset bus_oe", {7'd0, bus_oe}, 8'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            cfg_dir = tbl[i].dir; cfg_inte = tbl[i].inte; wr_en = tbl[i].wr; rd_en = tbl[i].rd;
            bus_in = tbl[i].bin; pa_in = tbl[i].pin; stb_n = tbl[i].stb; ack_n = tbl[i].ack;
            #1;
            chk($sformatf("row%0d bus_out", i), bus_out, tbl[i].e_bo);
            chk($sformatf("row%0d bus_oe", i), {7'd0, bus_oe}, {7'd0, tbl[i].e_boe});
            tick();
            chk($sformatf("row%0d ibf", i), {7'd0, ibf}, {7'd0, tbl[i].e_ibf});
            chk($sformatf("row%0d obf_n", i), {7'd0, obf_n}, {7'd0, tbl[i].e_obfn});
            chk($sformatf("row%0d intr", i), {7'd0, intr}, {7'd0, tbl[i].e_intr});
            chk($sformatf("row%0d overrun", i), {7'd0, overrun}, {7'd0, tbl[i].e_ovr});
            chk($sformatf("row%0d pa_oe", i), {7'd0, pa_oe}, {7'd0, tbl[i].e_paoe});
            chk($sformatf("row%0d pa_out", i), pa_out, tbl[i].e_pao);
        end
        wr_en = 1'b0; rd_en = 1'b0;

        // write coinciding with ack fall: write wins, later ack rise raises nothing
        ack_n = 1'b0;
        tick(); tick();
        wr_en = 1'b1; bus_in = 8'h99;
        tick();
        wr_en = 1'b0;
        chk("wr+ackfall obf_n", {7'd0, obf_n}, 8'd0);
        chk("wr+ackfall pa_out", pa_out, 8'h99);
        repeat (3) tick();
        chk("wr+ackfall obf_n later", {7'd0, obf_n}, 8'd0);
        ack_n = 1'b1;
        repeat (3) tick();
        chk("ackrise obf low intr", {7'd0, intr}, 8'd0);

        // INTE masking
        ack_n = 1'b0; repeat (3) tick();
        chk("ack obf_n", {7'd0, obf_n}, 8'd1);
        ack_n = 1'b1; repeat (3) tick();
        chk("ack intr", {7'd0, intr}, 8'd1);
        cfg_inte = 1'b0; #1;
        chk("inte off intr", {7'd0, intr}, 8'd0);
        tick();
        chk("inte off intr held", {7'd0, intr}, 8'd0);
        cfg_inte = 1'b1; #1;
        chk("inte on intr", {7'd0, intr}, 8'd1);
        tick();

        // direction switches clear the handshake, keep the latch
        cfg_dir = 1'b1; #1;
        chk("dir chg pa_oe before edge", {7'd0, pa_oe}, 8'd1);
        tick();
        chk("dir chg pa_oe", {7'd0, pa_oe}, 8'd0);
        chk("dir chg intr", {7'd0, intr}, 8'd0);
        chk("dir chg obf_n", {7'd0, obf_n}, 8'd1);
        strobe(8'h66);
        chk("cap66 ibf", {7'd0, ibf}, 8'd1);
        chk("cap66 intr", {7'd0, intr}, 8'd1);
        strobe(8'h44);
        chk("ovr44 overrun", {7'd0, overrun}, 8'd1);
        cfg_dir = 1'b0;
        tick();
        chk("to out ibf", {7'd0, ibf}, 8'd0);
        chk("to out overrun", {7'd0, overrun}, 8'd0);
        chk("to out intr", {7'd0, intr}, 8'd0);
        chk("to out pa_oe", {7'd0, pa_oe}, 8'd1);
        chk("to out pa_out kept", pa_out, 8'h99);
        cfg_dir = 1'b1;
        tick();
        chk("to in pa_oe", {7'd0, pa_oe}, 8'd0);
        rd_en = 1'b1; #1;
        chk("latch kept", bus_out, 8'h66);
        tick();
        rd_en = 1'b0;

        // read coinciding with strobe fall
        strobe(8'h66);
        pa_in = 8'h77; stb_n = 1'b0;
        tick(); tick();
        rd_en = 1'b1; #1;
        chk("rd+stb bus_out", bus_out, 8'h66);
        chk("rd+stb bus_oe", {7'd0, bus_oe}, 8'd1);
        tick();
        rd_en = 1'b0;
        chk("rd+stb ibf", {7'd0, ibf}, 8'd1);
        chk("rd+stb overrun", {7'd0, overrun}, 8'd0);
        chk("rd+stb intr", {7'd0, intr}, 8'd0);
        stb_n = 1'b1;
        repeat (3) tick();
        chk("rd+stb rise intr", {7'd0, intr}, 8'd1);
        rd_en = 1'b1; #1;
        chk("rd+stb new data", bus_out, 8'h77);
        tick();
        rd_en = 1'b0;
        chk("rd+stb drained ibf", {7'd0, ibf}, 8'd0);

        // ignored write in input mode, sub-period strobe glitch
        wr_en = 1'b1; bus_in = 8'hEE;
        tick();
        wr_en = 1'b0;
        chk("in-mode wr pa_out", pa_out, 8'h99);
        chk("in-mode wr obf_n", {7'd0, obf_n}, 8'd1);
        #3 stb_n = 1'b0;
        #4 stb_n = 1'b1;
        repeat (4) tick();
        chk("glitch ibf", {7'd0, ibf}, 8'd0);
        chk("glitch overrun", {7'd0, overrun}, 8'd0);

        // asynchronous reset mid-operation
        strobe(8'h12);
        strobe(8'h34);
        chk("pre-rst ibf", {7'd0, ibf}, 8'd1);
        chk("pre-rst intr", {7'd0, intr}, 8'd1);
        chk("pre-rst overrun", {7'd0, overrun}, 8'd1);
        rst_n = 1'b0; #1;
        chk("async rst ibf", {7'd0, ibf}, 8'd0);
        chk("async rst obf_n", {7'd0, obf_n}, 8'd1);
        chk("async rst intr", {7'd0, intr}, 8'd0);
        chk("async rst overrun", {7'd0, overrun}, 8'd0);
        chk("async rst pa_out", pa_out, 8'h00);
        tick(); tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("post-rst ibf", {7'd0, ibf}, 8'd0);
        chk("post-rst intr", {7'd0, intr}, 8'd0);
        rd_en = 1'b1; #1;
        chk("post-rst latch", bus_out, 8'h00);
        tick();
        rd_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
